range_bin_sequencer: RTL

- Sits directly downstream of the clock divider.
- Samples the divider's output (DIV_CLK) in the IN_CLK domain and turns each DIV_CLK rising edge into a one-cycle range-bin tick.
- On each radar trigger, sequences one sweep of BIN_COUNT range bins. Emits bin index plus valid strobe to the target-generation datapath.
- Counts triggers that arrive while a sweep is already running.

---
 rtl/range_bin_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/range_bin_sequencer.sv
// Range-bin sequencer: turns rising edges of the divided clock into bin ticks and
// steps one sweep of BIN_COUNT bins per radar trigger, counting triggers it had to ignore.
`timescale 1ns/1ps
module range_bin_sequencer #(
    parameter int BIN_COUNT   = 1024,
    parameter int BIN_BITS    = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                IN_CLK,
    input  logic                RESETN,
    input  logic                DIV_CLK,
    input  logic                ENABLE,
    input  logic                TRIG,
    output logic [BIN_BITS-1:0] BIN_IDX,
    output logic                BIN_VALID,
    output logic                SWEEP_ACTIVE,
    output logic                SWEEP_DONE,
    output logic [7:0]          OVERRUN_CNT
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_SWEEP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // One extra bit so a full 2^BIN_BITS sweep reaches its last index without wrapping.
    localparam logic [BIN_BITS:0] LAST_BIN = (BIN_BITS+1)'(BIN_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   tick_prev_q;
    logic                   tick_q, tick_d;
    logic                   trig_q;
    logic                   trig_rise;
    logic [1:0]             state_q, state_d;
    logic [BIN_BITS:0]      bin_cnt_q, bin_cnt_d;
    logic [BIN_BITS-1:0]    bin_idx_q, bin_idx_d;
    logic                   bin_valid_q, bin_valid_d;
    logic                   active_q, active_d;
    logic                   done_q, done_d;
    logic [7:0]             ovr_q, ovr_d;

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], DIV_CLK};
    assign tick_d    = sync_q[SYNC_STAGES-1] & ~tick_prev_q;
    assign trig_rise = TRIG & ~trig_q;

    always_comb begin
        state_d     = state_q;
        bin_cnt_d   = bin_cnt_q;
        bin_idx_d   = bin_idx_q;
        bin_valid_d = 1'b0;
        done_d      = 1'b0;
        ovr_d       = ovr_q;

        if ((state_q == S_SWEEP || state_q == S_DONE) && trig_rise && ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
        end

        if (!ENABLE) begin
            state_d   = S_IDLE;
            bin_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_WAIT;
                S_WAIT: begin
                    // A tick coinciding with the trigger is dropped; bin 0 waits for the next one.
                    if (trig_rise) begin
                        state_d   = S_SWEEP;
                        bin_cnt_d = '0;
                    end
                end
                S_SWEEP: begin
                    if (tick_q) begin
                        bin_idx_d   = bin_cnt_q[BIN_BITS-1:0];
                        bin_valid_d = 1'b1;
                        bin_cnt_d   = bin_cnt_q + (BIN_BITS+1)'(1);
                        if (bin_cnt_q == LAST_BIN) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    state_d = S_WAIT;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign active_d = (state_d == S_SWEEP);

    always_ff @(posedge IN_CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync_q      <= '0;
            tick_prev_q <= 1'b0;
            tick_q      <= 1'b0;
            trig_q      <= 1'b0;
            state_q     <= S_IDLE;
            bin_cnt_q   <= '0;
            bin_idx_q   <= '0;
            bin_valid_q <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            ovr_q       <= 8'd0;
        end else begin
            sync_q      <= sync_d;
            tick_prev_q <= sync_q[SYNC_STAGES-1];
            tick_q      <= tick_d;
            trig_q      <= TRIG;
            state_q     <= state_d;
            bin_cnt_q   <= bin_cnt_d;
            bin_idx_q   <= bin_idx_d;
            bin_valid_q <= bin_valid_d;
            active_q    <= active_d;
            done_q      <= done_d;
            ovr_q       <= ovr_d;
        end
    end

    assign BIN_IDX      = bin_idx_q;
    assign BIN_VALID    = bin_valid_q;
    assign SWEEP_ACTIVE = active_q;
    assign SWEEP_DONE   = done_q;
    assign OVERRUN_CNT  = ovr_q;

endmodule
